typ_compute_arbiter: RTL and testbench
======================================

Name: typ_compute_arbiter

Overview:
- Shares one typed-vector compute unit (the 2x2 Vec(Vec) operator FU inside the typed compute node) among NUM_REQ dataflow requesters.
- Round-robin arbitration on the issue side; in-order FU with no response backpressure, so the block holds credits and a response buffer.
- Returns each result to its originating requester through a ready/valid handshake.
- Sits between the memory-dataflow nodes and a single operator instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 128, packed operand/result width (2x2 vector of 32-bit elements).
- OP_W, 4, opcode width.
- MAX_INFLIGHT, 4, maximum issued-but-undelivered operations; depth of the ID FIFO and the response FIFO (power of 2).

Ports:
- clock  in  1  single clock; rising edge.
- reset  in  1  asynchronous, active-low reset (asserted = 0).
- in_valid  in  NUM_REQ  per-requester request valid.
- in_ready  out  NUM_REQ  per-requester request accept.
- in_left  in  NUM_REQ*DATA_W  left operands; requester i occupies bits [i*DATA_W +: DATA_W].
- in_right  in  NUM_REQ*DATA_W  right operands, packed the same way.
- in_op  in  NUM_REQ*OP_W  opcodes, packed the same way.
- out_valid  out  NUM_REQ  result valid; at most one bit set.
- out_ready  in  NUM_REQ  per-requester result accept.
- out_data  out  DATA_W  result, shared by all requesters.
- fu_req_valid  out  1  issue to the FU.
- fu_req_ready  in  1  FU accepts the issue.
- fu_left  out  DATA_W  left operand to the FU.
- fu_right  out  DATA_W  right operand to the FU.
- fu_op  out  OP_W  opcode to the FU.
- fu_resp_valid  in  1  FU result valid; in order, cannot be stalled.
- fu_resp_data  in  DATA_W  FU result.
- inflight  out  log2(MAX_INFLIGHT)+1  credits in use.
- err_resp  out  1  sticky flag: fu_resp_valid seen with no outstanding issue.

Behaviour:
- Reset (reset=0, async):
  - rr_ptr = NUM_REQ-1, so requester 0 has first priority.
  - Both FIFOs empty; inflight = 0; err_resp = 0.
  - out_valid, in_ready and fu_req_valid all forced to 0 while reset is low.
  - Reset mid-operation drops all buffered and in-flight results. The FU is reset by the same signal.
- Arbitration (combinational):
  - Candidates are requesters with in_valid=1, searched from index rr_ptr+1 upward with wrap-around.
  - The first candidate found is the grant g.
- Issue:
  - fu_req_valid = (any in_valid) && (inflight < MAX_INFLIGHT).
  - fu_left, fu_right and fu_op are muxed from g. When fu_req_valid=0 they are don't-care, driven 0.
  - in_ready[g] = fu_req_ready && (inflight < MAX_INFLIGHT); all other in_ready bits are 0.
  - Fire = fu_req_valid && fu_req_ready. On fire: push g into the ID FIFO and set rr_ptr <= g.
  - rr_ptr is unchanged when there is no fire. Issue latency is 0 cycles (combinational pass-through).
- Response capture:
  - fu_resp_valid pushes fu_resp_data into the response FIFO on the same edge.
  - There is no bypass. A result becomes visible on out_* one cycle after fu_resp_valid.
  - The credit rule guarantees the FIFO is never full on an arrival.
  - If fu_resp_valid=1 while the ID FIFO holds no undelivered entry that lacks a result: set err_resp and discard the data.
- Delivery:
  - While the response FIFO is non-empty: out_valid[id_head]=1 and out_data = data_head.
  - Delivery = out_valid[id_head] && out_ready[id_head]. On delivery, pop both FIFOs.
  - out_data is held stable while valid and not accepted.
  - Throughput is one delivery per cycle.
- Credit accounting:
  - inflight = ID FIFO occupancy, i.e. issued but not yet delivered.
  - Issue increments inflight; delivery decrements it.
  - Issue and delivery in the same cycle leave inflight unchanged.
  - At inflight == MAX_INFLIGHT: no issue; all in_ready bits are 0.
- Ordering: results leave in issue order. A stalled head requester blocks delivery to every other requester (head-of-line), which is intended.
- Pointers wrap modulo MAX_INFLIGHT; the occupancy counters are one bit wider than the pointers.

Test Plan:
- Single request: requester 2 issues L=R={1,2,3,4}, op=ADD; FU responds 3 cycles later with {2,4,6,8} -> out_valid=4'b0100 one cycle after fu_resp_valid, out_data={2,4,6,8}, inflight goes 1 then 0.
- Fairness: all 4 in_valid held high, fu_req_ready=1 -> grant order 0,1,2,3,0,1 on consecutive cycles.
- Credit limit: fu_resp_valid held low, all in_valid=1 -> exactly 4 issues; then fu_req_valid=0 and inflight=4; one delivery -> exactly one more issue.
- Backpressure and ordering: issue from requesters 1 then 3; out_ready[1]=0 for 5 cycles -> requester 3's result is not presented until requester 1 accepts; out_data stable throughout.
- Simultaneous issue, response and delivery in one cycle -> inflight unchanged, no data loss, FIFO order preserved.
- Error and reset: fu_resp_valid pulse at inflight=0 -> err_resp=1 and sticky. Then assert reset mid-stream with 3 in flight -> all outputs 0 immediately; after release requester 0 wins first.

Source files
------------

// File: rtl/typ_compute_arbiter_if.sv
// Bus bundle between the dataflow requesters, the arbiter and the shared
// 2x2 Vec(Vec) operator FU. The arbiter uses the slave view; the
// requesters/FU side (or a testbench) uses the master view.
interface typ_compute_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 128,
    parameter int OP_W    = 4
);
    // Requester issue side
    logic [NUM_REQ-1:0]        in_valid;
    logic [NUM_REQ-1:0]        in_ready;
    logic [NUM_REQ*DATA_W-1:0] in_left;
    logic [NUM_REQ*DATA_W-1:0] in_right;
    logic [NUM_REQ*OP_W-1:0]   in_op;

    // Requester result side
    logic [NUM_REQ-1:0]        out_valid;
    logic [NUM_REQ-1:0]        out_ready;
    logic [DATA_W-1:0]         out_data;

    // Functional-unit side
    logic                      fu_req_valid;
    logic                      fu_req_ready;
    logic [DATA_W-1:0]         fu_left;
    logic [DATA_W-1:0]         fu_right;
    logic [OP_W-1:0]           fu_op;
    logic                      fu_resp_valid;
    logic [DATA_W-1:0]         fu_resp_data;

    modport slave (
        input  in_valid, in_left, in_right, in_op, out_ready,
        input  fu_req_ready, fu_resp_valid, fu_resp_data,
        output in_ready, out_valid, out_data,
        output fu_req_valid, fu_left, fu_right, fu_op
    );

    modport master (
        output in_valid, in_left, in_right, in_op, out_ready,
        output fu_req_ready, fu_resp_valid, fu_resp_data,
        input  in_ready, out_valid, out_data,
        input  fu_req_valid, fu_left, fu_right, fu_op
    );
endinterface

// File: rtl/typ_compute_arbiter.sv
// Shares one in-order typed-vector compute FU among NUM_REQ requesters.
// Round-robin issue, credit-limited by MAX_INFLIGHT; an ID FIFO remembers
// who issued each operation and a response FIFO absorbs FU results (the FU
// cannot be stalled). Results return in issue order, so a stalled head
// requester blocks everyone behind it by design.
module typ_compute_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int DATA_W       = 128,
    parameter int OP_W         = 4,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic                          clock,
    input  logic                          reset,
    typ_compute_arbiter_if.slave          bus,
    output logic [$clog2(MAX_INFLIGHT):0] inflight,
    output logic                          err_resp
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int PTR_W = $clog2(MAX_INFLIGHT);
    localparam int CNT_W = PTR_W + 1;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [ID_W-1:0]   r_rr_ptr;

    logic [ID_W-1:0]   r_id_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]  r_id_wr;
    logic [PTR_W-1:0]  r_id_rd;
    logic [CNT_W-1:0]  r_id_cnt;

    logic [DATA_W-1:0] r_rsp_mem [MAX_INFLIGHT];
    logic [PTR_W-1:0]  r_rsp_wr;
    logic [PTR_W-1:0]  r_rsp_rd;
    logic [CNT_W-1:0]  r_rsp_cnt;

    logic              r_err;

    // ------------------------------------------------------------------
    // Per-requester operand views
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_left  [NUM_REQ];
    logic [DATA_W-1:0] w_right [NUM_REQ];
    logic [OP_W-1:0]   w_op    [NUM_REQ];

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
        assign w_left[gi]  = bus.in_left[gi*DATA_W +: DATA_W];
        assign w_right[gi] = bus.in_right[gi*DATA_W +: DATA_W];
        assign w_op[gi]    = bus.in_op[gi*OP_W +: OP_W];
    end

    // ------------------------------------------------------------------
    // Combinational control
    // ------------------------------------------------------------------
    logic [ID_W-1:0]    w_grant;
    logic [ID_W-1:0]    w_scan;
    logic               w_found;
    logic               w_any;
    logic               w_credit;
    logic               w_issue_ok;
    logic               w_fire;
    logic               w_pending;
    logic               w_rsp_push;
    logic               w_rsp_nonempty;
    logic [ID_W-1:0]    w_id_head;
    logic [NUM_REQ-1:0] w_out_valid;
    logic               w_deliver;

    // Step a requester index forward with wrap at NUM_REQ-1.
    function automatic logic [ID_W-1:0] f_next(input logic [ID_W-1:0] x);
        return (x == ID_W'(NUM_REQ - 1)) ? '0 : x + ID_W'(1);
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment, otherwise an untaken path would infer a latch.
        w_grant = '0;
        w_found = 1'b0;
        w_scan  = f_next(r_rr_ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && bus.in_valid[w_scan]) begin
                w_found = 1'b1;
                w_grant = w_scan;
            end
            w_scan = f_next(w_scan);
        end
    end

    assign w_any      = |bus.in_valid;
    assign w_credit   = (r_id_cnt < CNT_W'(MAX_INFLIGHT));
    // Reset gating keeps the combinational handshakes quiet while reset is low.
    assign w_issue_ok = reset && w_any && w_credit;
    assign w_fire     = w_issue_ok && bus.fu_req_ready;

    // A response is legal only if some issued entry is still awaiting its result.
    assign w_pending      = (r_id_cnt > r_rsp_cnt);
    assign w_rsp_push     = bus.fu_resp_valid && w_pending;
    assign w_rsp_nonempty = (r_rsp_cnt != '0);
    assign w_id_head      = r_id_mem[r_id_rd];
    assign w_out_valid    = w_rsp_nonempty ? (NUM_REQ'(1) << w_id_head) : '0;
    assign w_deliver      = |(w_out_valid & bus.out_ready);

    // Issue path: operands pass straight through from the granted requester.
    always_comb begin
        bus.fu_req_valid = w_issue_ok;
        bus.fu_left      = '0;
        bus.fu_right     = '0;
        bus.fu_op        = '0;
        bus.in_ready     = '0;
        if (w_issue_ok) begin
            bus.fu_left  = w_left[w_grant];
            bus.fu_right = w_right[w_grant];
            bus.fu_op    = w_op[w_grant];
            if (bus.fu_req_ready) begin
                bus.in_ready = NUM_REQ'(1) << w_grant;
            end
        end
    end

    // Delivery path: head of the response FIFO goes to its issuer.
    assign bus.out_valid = w_out_valid;
    assign bus.out_data  = w_rsp_nonempty ? r_rsp_mem[r_rsp_rd] : '0;

    assign inflight = r_id_cnt;
    assign err_resp = r_err;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------

    // Arbitration pointer advances to the granted requester on each fire.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: sequential state uses non-blocking '<=' so every register
        // samples pre-edge values regardless of statement order.
        if (!reset) begin
            r_rr_ptr <= ID_W'(NUM_REQ - 1);
        end else if (w_fire) begin
            r_rr_ptr <= w_grant;
        end
    end

    // ID FIFO pointers and occupancy (occupancy == credits in use).
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_id_wr  <= '0;
            r_id_rd  <= '0;
            r_id_cnt <= '0;
        end else begin
            if (w_fire) begin
                r_id_wr <= r_id_wr + PTR_W'(1);
            end
            if (w_deliver) begin
                r_id_rd <= r_id_rd + PTR_W'(1);
            end
            r_id_cnt <= r_id_cnt + CNT_W'(w_fire) - CNT_W'(w_deliver);
        end
    end

    // Response FIFO pointers and occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_rsp_wr  <= '0;
            r_rsp_rd  <= '0;
            r_rsp_cnt <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_wr <= r_rsp_wr + PTR_W'(1);
            end
            if (w_deliver) begin
                r_rsp_rd <= r_rsp_rd + PTR_W'(1);
            end
            r_rsp_cnt <= r_rsp_cnt + CNT_W'(w_rsp_push) - CNT_W'(w_deliver);
        end
    end

    // FIFO storage: written on push, read at the head pointer.
    always_ff @(posedge clock) begin
        // NOTE: storage arrays are not reset; the occupancy counters decide
        // what is valid, so clearing the contents would buy nothing.
        if (w_fire) begin
            r_id_mem[r_id_wr] <= w_grant;
        end
        if (w_rsp_push) begin
            r_rsp_mem[r_rsp_wr] <= bus.fu_resp_data;
        end
    end

    // Sticky error: FU produced a result nobody is waiting for.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (bus.fu_resp_valid && !w_pending) begin
            r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_typ_compute_arbiter.sv
// Directed bench for typ_compute_arbiter: a cycle-by-cycle vector table
// covering fairness, credit limit and concurrent issue/response/delivery,
// plus hand sequences for latency, backpressure, error and reset.
module tb_typ_compute_arbiter;

    localparam int NUM_REQ = 4;
    localparam int DATA_W  = 128;
    localparam int OP_W    = 4;
    localparam int MAX_INF = 4;

    logic       clock;
    logic       reset;
    logic [2:0] inflight;
    logic       err_resp;

    typ_compute_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W)) bus ();

    typ_compute_arbiter #(
        .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .OP_W(OP_W), .MAX_INFLIGHT(MAX_INF)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .bus      (bus),
        .inflight (inflight),
        .err_resp (err_resp)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  iv;
        logic        rdy;
        logic        rv;
        logic [31:0] rtag;
        logic [3:0]  ordy;
        logic [3:0]  e_ir;
        logic        e_fv;
        logic [3:0]  e_op;
        logic [3:0]  e_ov;
        logic [31:0] e_tag;
        logic [2:0]  e_inf;
    } vec_t;

    function automatic vec_t mk(input logic [3:0] iv, input logic rdy, input logic rv,
                                input logic [31:0] rtag, input logic [3:0] ordy,
                                input logic [3:0] e_ir, input logic e_fv, input logic [3:0] e_op,
                                input logic [3:0] e_ov, input logic [31:0] e_tag,
                                input logic [2:0] e_inf);
        vec_t v;
        v.iv = iv; v.rdy = rdy; v.rv = rv; v.rtag = rtag; v.ordy = ordy;
        v.e_ir = e_ir; v.e_fv = e_fv; v.e_op = e_op; v.e_ov = e_ov;
        v.e_tag = e_tag; v.e_inf = e_inf;
        return v;
    endfunction

    // Watchdog: the bench must never hang.
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         tbl[$];
        logic [127:0] opnd;
        logic [127:0] l2;
        logic [127:0] sum2;
        logic [127:0] d1;
        logic [127:0] d3;

        l2   = {32'd4, 32'd3, 32'd2, 32'd1};
        sum2 = {32'd8, 32'd6, 32'd4, 32'd2};
        d1   = {4{32'hB1}};
        d3   = {4{32'hB3}};

        // Requester r uses opcode r+1; requester 2 carries {1,2,3,4}.
        for (int r = 0; r < NUM_REQ; r++) begin
            opnd = (r == 2) ? l2 : {4{32'(r + 10)}};
            bus.in_left[r*DATA_W +: DATA_W]  = opnd;
            bus.in_right[r*DATA_W +: DATA_W] = opnd;
            bus.in_op[r*OP_W +: OP_W]        = 4'(r + 1);
        end

        //                iv    rdy   rv    rtag   ordy  | e_ir  fv    op    e_ov  e_tag  inf
        // Fairness 0,1,2,3 then credit stop at 4
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h1, 1'b1, 4'h1, 4'h0, 32'h00, 3'd0));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h2, 1'b1, 4'h2, 4'h0, 32'h00, 3'd1));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h4, 1'b1, 4'h3, 4'h0, 32'h00, 3'd2));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h8, 1'b1, 4'h4, 4'h0, 32'h00, 3'd3));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd4));
        // Response arrives; visible next cycle; one delivery frees one credit
        tbl.push_back(mk(4'hF, 1'b1, 1'b1, 32'h11, 4'h0, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd4));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'h0, 4'h0, 1'b0, 4'h0, 4'h1, 32'h11, 3'd4));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h1, 32'h11, 3'd4));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h1, 1'b1, 4'h1, 4'h0, 32'h00, 3'd3));
        tbl.push_back(mk(4'hF, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd4));
        // Responses stream while delivering; issue+response+delivery in one cycle
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, 32'h22, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd4));
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, 32'h33, 4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 32'h22, 3'd4));
        tbl.push_back(mk(4'hF, 1'b1, 1'b1, 32'h44, 4'hF, 4'h2, 1'b1, 4'h2, 4'h4, 32'h33, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h8, 32'h44, 3'd3));
        // FU not ready: valid but no fire, pointer holds
        tbl.push_back(mk(4'hF, 1'b0, 1'b1, 32'h55, 4'hF, 4'h0, 1'b1, 4'h3, 4'h0, 32'h00, 3'd2));
        tbl.push_back(mk(4'hF, 1'b1, 1'b1, 32'h66, 4'hF, 4'h4, 1'b1, 4'h3, 4'h1, 32'h55, 3'd2));
        // Sparse requests: wrap-around search
        tbl.push_back(mk(4'hA, 1'b1, 1'b0, 32'h00, 4'hF, 4'h8, 1'b1, 4'h4, 4'h2, 32'h66, 3'd2));
        tbl.push_back(mk(4'h2, 1'b1, 1'b0, 32'h00, 4'hF, 4'h2, 1'b1, 4'h2, 4'h0, 32'h00, 3'd2));
        // Drain with a held head
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, 32'h77, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, 32'h88, 4'h0, 4'h0, 1'b0, 4'h0, 4'h4, 32'h77, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b1, 32'h99, 4'h4, 4'h0, 1'b0, 4'h0, 4'h4, 32'h77, 3'd3));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h8, 32'h88, 3'd2));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h2, 32'h99, 3'd1));
        tbl.push_back(mk(4'h0, 1'b1, 1'b0, 32'h00, 4'hF, 4'h0, 1'b0, 4'h0, 4'h0, 32'h00, 3'd0));

        // ---------------- Reset state ----------------
        reset             = 1'b0;
        bus.in_valid      = 4'hF;
        bus.fu_req_ready  = 1'b1;
        bus.fu_resp_valid = 1'b0;
        bus.fu_resp_data  = '0;
        bus.out_ready     = 4'hF;
        #3;
        check("rst.fu_req_valid", bus.fu_req_valid, 1'b0);
        check("rst.in_ready", bus.in_ready, 4'h0);
        check("rst.out_valid", bus.out_valid, 4'h0);
        check("rst.inflight", inflight, 3'd0);
        check("rst.err_resp", err_resp, 1'b0);
        bus.in_valid = 4'h0;
        @(negedge clock);
        reset = 1'b1;

        // ---------------- Vector table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            bus.in_valid      = tbl[i].iv;
            bus.fu_req_ready  = tbl[i].rdy;
            bus.fu_resp_valid = tbl[i].rv;
            bus.fu_resp_data  = {4{tbl[i].rtag}};
            bus.out_ready     = tbl[i].ordy;
            #1;
            check($sformatf("v%0d.in_ready", i), bus.in_ready, tbl[i].e_ir);
            check($sformatf("v%0d.fu_req_valid", i), bus.fu_req_valid, tbl[i].e_fv);
            check($sformatf("v%0d.fu_op", i), bus.fu_op, tbl[i].e_op);
            check($sformatf("v%0d.out_valid", i), bus.out_valid, tbl[i].e_ov);
            check($sformatf("v%0d.out_data", i), bus.out_data, {4{tbl[i].e_tag}});
            check($sformatf("v%0d.inflight", i), inflight, tbl[i].e_inf);
        end
        check("tbl.err_resp", err_resp, 1'b0);

        // ---------------- Single request, 3-cycle FU latency ----------------
        @(negedge clock);
        bus.in_valid = 4'h4; bus.fu_req_ready = 1'b1; bus.fu_resp_valid = 1'b0;
        bus.out_ready = 4'h0;
        #1;
        check("one.in_ready", bus.in_ready, 4'h4);
        check("one.fu_left", bus.fu_left, l2);
        check("one.fu_right", bus.fu_right, l2);
        check("one.fu_op", bus.fu_op, 4'h3);
        @(negedge clock);
        bus.in_valid = 4'h0;
        #1;
        check("one.inflight1", inflight, 3'd1);
        @(negedge clock);
        @(negedge clock);
        bus.fu_resp_valid = 1'b1; bus.fu_resp_data = sum2;
        #1;
        check("one.no_bypass", bus.out_valid, 4'h0);
        @(negedge clock);
        bus.fu_resp_valid = 1'b0;
        #1;
        check("one.out_valid", bus.out_valid, 4'h4);
        check("one.out_data", bus.out_data, sum2);
        check("one.inflight_held", inflight, 3'd1);
        bus.out_ready = 4'h4;
        @(negedge clock);
        bus.out_ready = 4'h0;
        #1;
        check("one.delivered", bus.out_valid, 4'h0);
        check("one.inflight0", inflight, 3'd0);

        // ---------------- Backpressure and ordering ----------------
        @(negedge clock);
        bus.in_valid = 4'h2;
        #1;
        check("bp.grant1", bus.in_ready, 4'h2);
        @(negedge clock);
        bus.in_valid = 4'h8;
        #1;
        check("bp.grant3", bus.in_ready, 4'h8);
        @(negedge clock);
        bus.in_valid = 4'h0;
        bus.fu_resp_valid = 1'b1; bus.fu_resp_data = d1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            bus.fu_resp_valid = (k == 0);
            bus.fu_resp_data  = d3;
            bus.out_ready     = 4'h8;
            #1;
            check($sformatf("bp.hold%0d.valid", k), bus.out_valid, 4'h2);
            check($sformatf("bp.hold%0d.data", k), bus.out_data, d1);
        end
        @(negedge clock);
        bus.fu_resp_valid = 1'b0;
        bus.out_ready = 4'hA;
        #1;
        check("bp.release.valid", bus.out_valid, 4'h2);
        @(negedge clock);
        #1;
        check("bp.second.valid", bus.out_valid, 4'h8);
        check("bp.second.data", bus.out_data, d3);
        @(negedge clock);
        bus.out_ready = 4'h0;
        #1;
        check("bp.drained", bus.out_valid, 4'h0);
        check("bp.inflight", inflight, 3'd0);

        // ---------------- Spurious response -> sticky error ----------------
        @(negedge clock);
        bus.fu_resp_valid = 1'b1; bus.fu_resp_data = {4{32'hEE}};
        #1;
        check("err.before", err_resp, 1'b0);
        @(negedge clock);
        bus.fu_resp_valid = 1'b0;
        #1;
        check("err.set", err_resp, 1'b1);
        check("err.no_out", bus.out_valid, 4'h0);
        check("err.inflight", inflight, 3'd0);
        repeat (3) @(negedge clock);
        #1;
        check("err.sticky", err_resp, 1'b1);

        // ---------------- Reset mid-stream with 3 in flight ----------------
        @(negedge clock);
        bus.in_valid = 4'hF;
        repeat (2) @(negedge clock);
        @(negedge clock);
        bus.in_valid = 4'h0;
        bus.fu_resp_valid = 1'b1; bus.fu_resp_data = {4{32'hC0}};
        @(negedge clock);
        bus.fu_resp_valid = 1'b0;
        bus.in_valid = 4'hF;
        #1;
        check("mid.out_valid", bus.out_valid, 4'h1);
        check("mid.inflight", inflight, 3'd3);
        #1;
        reset = 1'b0;
        #1;
        check("mid.rst.fu_req_valid", bus.fu_req_valid, 1'b0);
        check("mid.rst.in_ready", bus.in_ready, 4'h0);
        check("mid.rst.out_valid", bus.out_valid, 4'h0);
        check("mid.rst.out_data", bus.out_data, 128'h0);
        check("mid.rst.inflight", inflight, 3'd0);
        check("mid.rst.err_resp", err_resp, 1'b0);
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("post.in_ready", bus.in_ready, 4'h1);
        check("post.fu_op", bus.fu_op, 4'h1);
        check("post.out_valid", bus.out_valid, 4'h0);
        @(negedge clock);
        bus.in_valid = 4'h0;
        #1;
        check("post.inflight", inflight, 3'd1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
